// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- 16x-oversampled UART receiver feeding a first-word-fall-through
// byte FIFO.
//
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing with an
// even-parity check. When it is left undefined the frame is 8N1 and
// parity_err is tied low.
//
// Ports
//   clk_50_clk   in   fabric clock; every register is on its rising edge
//   reset_reset  in   synchronous, active-high reset
//   rx_in        in   asynchronous serial line, idles high
//   rx_data      out  head-of-FIFO byte; 0 while the FIFO is empty
//   rx_valid     out  FIFO non-empty
//   rx_ready     in   consumer accept; rx_valid & rx_ready pops one byte
//   fifo_count   out  bytes held, 0..FIFO_DEPTH
//   frame_err    out  1-cycle pulse: stop bit sampled low
//   overrun      out  1-cycle pulse: byte dropped because the FIFO was full
//   parity_err   out  1-cycle pulse: parity mismatch (8E1 build only)
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_50_clk,
  input  logic                          reset_reset,
  input  logic                          rx_in,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int DIV = CLK_HZ / (16 * BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t          state, state_n;
  logic            s1, s2, s_prev;   // synchronizer plus one flop for edge detect
  logic [DW-1:0]   div_cnt;
  logic [3:0]      tick_cnt;         // ticks within the current bit
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            tick, samp;
  logic            push_req, fe_raw, pe_raw;
`ifdef UART_RX_PARITY_EN
  logic            par_bad;
`endif

  // FIFO
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, pop, push_ok;

  assign tick = (div_cnt == DW'(DIV - 1));
  // Start bit is checked half a bit in; every later bit is 16 ticks further on.
  assign samp = tick && (tick_cnt == ((state == START) ? 4'd7 : 4'd15));

  always_comb begin
    state_n  = state;
    push_req = 1'b0;
    fe_raw   = 1'b0;
    pe_raw   = 1'b0;
    case (state)
      IDLE:      if (s_prev && !s2) state_n = START;
      START:     if (samp) state_n = s2 ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:      if (samp && bit_cnt == 3'd7) state_n = PARITY;
      PARITY: begin
        if (samp) begin
          pe_raw  = (s2 != ^shreg);
          state_n = STOP;
        end
      end
`else
      DATA:      if (samp && bit_cnt == 3'd7) state_n = STOP;
`endif
      STOP: begin
        if (samp) begin
          if (s2) begin
`ifdef UART_RX_PARITY_EN
            push_req = !par_bad;
`else
            push_req = 1'b1;
`endif
            state_n  = IDLE;
          end else begin
            fe_raw  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: if (s2) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_50_clk) begin
    if (reset_reset) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      s_prev   <= 1'b1;
      state    <= IDLE;
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      s1     <= rx_in;
      s2     <= s1;
      s_prev <= s2;
      state  <= state_n;
      if (state == IDLE) begin
        // Holding counters at 0 here aligns bit timing to the detected edge.
        div_cnt  <= '0;
        tick_cnt <= '0;
        bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
        par_bad  <= 1'b0;
`endif
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) tick_cnt <= (state == START && samp) ? 4'd0 : tick_cnt + 4'd1;
        if (state == DATA && samp) begin
          shreg   <= {s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
`ifdef UART_RX_PARITY_EN
        if (state == PARITY && samp) par_bad <= pe_raw;
`endif
      end
    end
  end

  // Flags are gated so nothing pulses in a reset cycle.
  assign frame_err = fe_raw & ~reset_reset;
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_raw & ~reset_reset;
`else
  assign parity_err = 1'b0;
`endif

  assign full     = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign rx_valid = (fifo_count != '0);
  assign pop      = rx_valid & rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok  = push_req & ~reset_reset & (~full | pop);
  assign overrun  = push_req & ~reset_reset & full & ~pop;
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk_50_clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk_50_clk) begin
    if (reset_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo. A serial driver builds
// frames bit by bit; a queue-based model of the receive buffer and flag
// counters predicts fifo_count, popped bytes and pulse counts. The line rate
// is raised (10 clocks per oversample tick, 160 per bit) to keep run time short.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CLK_HZ = 50000000;
  localparam int BAUD   = 312500;
  localparam int DEPTH  = 16;
  localparam int DIV    = CLK_HZ / (16 * BAUD);
  localparam int BIT    = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Clocks from the start-bit edge to the mid-stop push edge: 2 sync flops
  // plus half a bit and NB-1 whole bits of ticks.
  localparam int PUSH_OFF = 2 + DIV * (8 + 16 * (NB - 1));

  logic clk = 1'b0, rst = 1'b1, rx_in = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, parity_err;
  logic [$clog2(DEPTH):0] fifo_count;

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk_50_clk(clk), .reset_reset(rst), .rx_in(rx_in), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_count(fifo_count),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (overrun)    ov_cnt++;
    if (parity_err) pe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_fe"}, fe_cnt, exp_fe);
    chk({tag, "_ov"}, ov_cnt, exp_ov);
    chk({tag, "_pe"}, pe_cnt, exp_pe);
  endtask

  // Sends one frame then one idle bit. pop_now raises rx_ready in exactly the
  // push cycle; low_hold keeps the line low that many cycles after the stop bit.
  task automatic send_frame(input logic [7:0] d, input bit stop_v, input bit par_ok,
                            input bit pop_now, input int low_hold);
    logic [11:0] fr;
    int total;
    fr = '1;
    fr[0]   = 1'b0;
    fr[8:1] = d;
`ifdef UART_RX_PARITY_EN
    fr[9]  = (^d) ^ ~par_ok;
    fr[10] = stop_v;
`else
    fr[9]  = stop_v;
`endif
    total = NB * BIT + low_hold + BIT;
    for (int c = 0; c < total; c++) begin
      if (c < NB * BIT)                 rx_in = fr[c / BIT];
      else if (c < NB * BIT + low_hold) rx_in = 1'b0;
      else                              rx_in = 1'b1;
      rx_ready = pop_now && (c == PUSH_OFF);
      if (c == PUSH_OFF) begin
        chk("cnt_pre", fifo_count, exp_q.size());
        if (pop_now && exp_q.size() > 0) begin
          chk("pop_dat", rx_data, exp_q[0]);
          void'(exp_q.pop_front());
        end
        if (!par_ok) exp_pe++;
        if (!stop_v) exp_fe++;
        else if (par_ok) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(d);
          else exp_ov++;
        end
      end
      if (c == PUSH_OFF + 1) chk("cnt_post", fifo_count, exp_q.size());
      @(negedge clk);
    end
    rx_ready = 1'b0;
    chk("cnt_end", fifo_count, exp_q.size());
    chk_flags("frm");
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      chk("drain_v", rx_valid, 1);
      chk("drain_d", rx_data, exp_q[0]);
      rx_ready = 1'b1;
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    rx_ready = 1'b0;
    chk("drain_empty_v", rx_valid, 0);
    chk("drain_empty_c", fifo_count, 0);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog timeout n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic [11:0] pf;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out", {rx_valid, fifo_count, rx_data, frame_err, overrun, parity_err}, 0);
    rst = 1'b0;
    idle(2 * BIT);
    chk("idle_out", {rx_valid, fifo_count, rx_data}, 0);
    chk_flags("idle");

    // basic frame
    send_frame(8'h55, 1, 1, 0, 0);
    chk("f55_d", rx_data, 8'h55);
    chk("f55_v", rx_valid, 1);

    // glitch shorter than half a bit
    rx_in = 1'b0;
    repeat (BIT * 3 / 8) @(negedge clk);
    idle(2 * BIT);
    chk("glitch_cnt", fifo_count, exp_q.size());
    chk_flags("glitch");
    send_frame(8'hA5, 1, 1, 0, 0);
    drain();

    // empty pops are ignored
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    rx_ready = 1'b0;
    chk("empty_pop", fifo_count, 0);

    // framing error with line held low
    send_frame(8'hA3, 0, 1, 0, 2000);
    chk("fe_cnt0", fifo_count, 0);
    send_frame(8'h5A, 1, 1, 0, 0);
    drain();

    // overrun: 17 frames, then a full-level push with simultaneous pop
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1, 1, 0, 0);
    chk("full_cnt", fifo_count, 16);
    send_frame(8'h11, 1, 1, 1, 0);
    chk("full_pp_cnt", fifo_count, 16);
    drain();

    // reset in the middle of data bit 4
    send_frame(8'h11, 1, 1, 0, 0);
    pf = {3'b111, 8'h2D, 1'b0};
    for (int c = 0; c < 5 * BIT + BIT / 2; c++) begin
      rx_in = pf[c / BIT];
      @(negedge clk);
    end
    rst = 1'b1;
    rx_in = 1'b1;
    @(negedge clk);
    chk("mrst_out", {rx_valid, fifo_count, rx_data, frame_err, overrun, parity_err}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_rel", {rx_valid, fifo_count, rx_data}, 0);
    idle(2 * BIT);
    chk_flags("mrst");
    send_frame(8'h3C, 1, 1, 0, 0);
    chk("f3c_d", rx_data, 8'h3C);
    chk("f3c_c", fifo_count, 1);
    drain();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1, 0, 0, 0);
    chk("par_bad_cnt", fifo_count, 0);
    send_frame(8'h07, 1, 1, 0, 0);
    chk("par_ok_d", rx_data, 8'h07);
    drain();
`endif

    // randomized frames, stop errors and same-cycle pops
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
`ifdef UART_RX_PARITY_EN
      send_frame(d, $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, 0);
`else
      send_frame(d, $urandom_range(0, 4) != 0, 1'b1, $urandom_range(0, 1) == 1, 0);
`endif
      if (i % 4 == 3) drain();
    end
    drain();
    chk_flags("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_HZ, default 50000000, fabric clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate in bit/s.
REQ-003 Parameter FIFO_DEPTH, default 16, receive buffer depth; power of two, 2..256.
REQ-004 clk_50_clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset_reset  in  1  reset; synchronous, active-high.
REQ-006 rx_in  in  1  serial line from the HPS UART TX pin (hps_io_uart0/1 TX); asynchronous; idles high.
REQ-007 rx_data  out  8  head-of-FIFO byte; valid only while rx_valid=1.
REQ-008 rx_valid  out  1  FIFO non-empty.
REQ-009 rx_ready  in  1  consumer accept; a pop occurs when rx_valid=1 and rx_ready=1.
REQ-010 fifo_count  out  log2(FIFO_DEPTH)+1  bytes held, 0..FIFO_DEPTH.
REQ-011 frame_err  out  1  one-cycle pulse: stop bit sampled low.
REQ-012 overrun  out  1  one-cycle pulse: byte dropped because the FIFO was full.
REQ-013 parity_err  out  1  one-cycle pulse: parity mismatch; constant 0 without UART_RX_PARITY_EN.

Function
REQ-014 rx_in shall pass through a 2-flop synchronizer before any use.
REQ-015 Oversample tick shall occur every DIV = CLK_HZ/(16*BAUD) cycles (integer division; 27 at defaults), one bit = 16 ticks = 432 cycles.
REQ-016 The tick counter shall restart at 0 on the IDLE->START transition, so sampling is aligned to the detected falling edge.
REQ-017 FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH.
REQ-018 IDLE->START on a synchronized high-to-low transition of rx_in.
REQ-019 START: at tick 8, rx_in low -> DATA; rx_in high -> IDLE (glitch reject, no flag).
REQ-020 DATA: sample every 16 ticks at mid-bit, 8 bits, LSB first; after bit 7 -> STOP (or PARITY when enabled).
REQ-021 STOP: at mid-bit, rx_in high -> push byte, IDLE; rx_in low -> frame_err pulse, byte discarded, WAIT_HIGH.
REQ-022 WAIT_HIGH -> IDLE on the first cycle the synchronized rx_in is high; no start detection occurs in WAIT_HIGH.
REQ-023 Push occurs in the mid-stop sample cycle; rx_valid and fifo_count update on the next cycle.
REQ-024 FIFO is first-word-fall-through: rx_data shows the oldest byte whenever rx_valid=1; a pop advances it the next cycle.
REQ-025 Push while full and no pop: byte dropped, overrun pulse, FIFO contents unchanged.
REQ-026 Push and pop in the same cycle while full: both succeed, fifo_count unchanged, no overrun.
REQ-027 Push and pop in the same cycle at any other level: fifo_count unchanged, order preserved.
REQ-028 Pop while empty is ignored; fifo_count never wraps below 0 or above FIFO_DEPTH.
REQ-029 Read and write pointers shall wrap modulo FIFO_DEPTH.

Reset
REQ-030 While reset_reset=1 on a clock edge: FSM=IDLE, tick/bit counters=0, FIFO empty, fifo_count=0, rx_valid=0, rx_data=0, frame_err=overrun=parity_err=0.
REQ-031 Synchronizer flops shall reset to 1 so that no false start is detected on reset release.
REQ-032 Reset mid-frame shall abandon the partial byte; no flag is pulsed for it.

Configuration
REQ-033 Macro UART_RX_PARITY_EN defined: frame is 8E1; the PARITY state samples one even-parity bit after DATA; on mismatch a parity_err pulse is issued in the sample cycle, STOP is still checked, and the byte is never pushed.
REQ-034 Macro UART_RX_PARITY_EN undefined: frame is 8N1, no PARITY state, parity_err tied 0.

Verification
REQ-035 Defaults, 8N1 frame 0x55 at 432 cycles/bit -> rx_valid=1, rx_data=0x55, fifo_count=1 one cycle after the mid-stop sample.
REQ-036 100-cycle low glitch on an idle rx_in -> no push, no flags, FSM back in IDLE; a following frame 0xA5 is received correctly.
REQ-037 Frame 0xA3 with stop bit low, line held low 2000 cycles -> single frame_err pulse, fifo_count=0, no further start until rx_in returns high.
REQ-038 17 frames 0x00..0x10 with rx_ready=0 -> fifo_count=16, one overrun pulse on the 17th; draining yields 0x00..0x0F in order.
REQ-039 reset_reset pulsed during data bit 4 of a frame, then clean frame 0x3C -> all outputs 0 after reset, then rx_data=0x3C, fifo_count=1.
REQ-040 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 (correct value 1) -> parity_err pulse, fifo_count=0; 0x07 with parity bit 1 -> pushed.
